// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter giving two requesters (reqN_*/rspN_*) turns on one shared I2C master (m_*), with timeout abort; grant shows the owner
module i2c_req_arbiter #(
  parameter int TIMEOUT_CYC = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_rw,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  output logic [1:0] rsp0_err,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_rw,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic [1:0] rsp1_err,
  output logic       m_start,
  output logic       m_rw,
  output logic [6:0] m_addr,
  output logic [7:0] m_wdata,
  output logic       m_abort,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic       m_nack,
  input  logic [7:0] m_rdata,
  output logic [1:0] grant
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, ABORT, RESP} state_t;
  state_t r_state, w_next;
  logic r_owner, r_last_owner, r_rw;
  logic [6:0] r_addr;
  logic [7:0] r_wdata;
  logic [15:0] r_timer;
  logic [7:0] r_rsp_rdata [2];
  logic [1:0] r_rsp_err [2];
  logic w_sel, w_hs, w_timeout, w_fin_done, w_fin_abort;
  logic [1:0] w_err;
  logic [7:0] w_rdata;
  assign w_sel = (req0_valid & req1_valid) ? ~r_last_owner : req1_valid;
  assign w_hs = (r_state == IDLE) & (w_sel ? req1_valid : req0_valid);
  assign w_timeout = r_timer == 16'(TIMEOUT_CYC - 1);
  assign w_fin_done = (r_state == WAIT_DONE) & m_done;
  assign w_fin_abort = (r_state == ABORT) & ~m_busy;
  assign w_err = w_fin_done ? {1'b0, m_nack} : 2'b10;
  assign w_rdata = (w_fin_done & r_rw & ~m_nack) ? m_rdata : 8'h00;
  assign m_rw = r_rw;
  assign m_addr = r_addr;
  assign m_wdata = r_wdata;
  assign rsp0_rdata = r_rsp_rdata[0];
  assign rsp1_rdata = r_rsp_rdata[1];
  assign rsp0_err = r_rsp_err[0];
  assign rsp1_err = r_rsp_err[1];
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    req0_ready = (r_state == IDLE) & ~w_sel;
    req1_ready = (r_state == IDLE) & w_sel;
    m_start = r_state == ISSUE;
    m_abort = (r_state == WAIT_DONE) & ~m_done & w_timeout;
    rsp0_valid = (r_state == RESP) & ~r_owner;
    rsp1_valid = (r_state == RESP) & r_owner;
    grant = (r_state == IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
    case (r_state)
      IDLE:      w_next = w_hs ? ISSUE : IDLE;
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: w_next = m_done ? RESP : (w_timeout ? ABORT : WAIT_DONE);
      ABORT:     w_next = m_busy ? ABORT : RESP;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_last_owner <= 1'b1;
      r_rw <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_timer <= '0;
      r_rsp_rdata[0] <= '0;
      r_rsp_rdata[1] <= '0;
      r_rsp_err[0] <= '0;
      r_rsp_err[1] <= '0;
    end else begin
      if (w_hs) begin
        r_owner <= w_sel;
        r_rw <= w_sel ? req1_rw : req0_rw;
        r_addr <= w_sel ? req1_addr : req0_addr;
        r_wdata <= w_sel ? req1_wdata : req0_wdata;
      end
      if (r_state == ISSUE) r_timer <= '0;
      else if ((r_state == WAIT_DONE) & ~m_done & ~w_timeout) r_timer <= r_timer + 16'd1;
      // response registers are loaded on the way into RESP so they are valid with the pulse
      if (w_fin_done | w_fin_abort) begin
        r_rsp_rdata[r_owner] <= w_rdata;
        r_rsp_err[r_owner] <= w_err;
      end
      if (r_state == RESP) r_last_owner <= r_owner;
    end
  end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: randomized transaction-level check of i2c_req_arbiter against a behavioural model
module tb_i2c_req_arbiter;
  localparam int TO = 100;
  logic clk, reset;
  logic req0_valid, req0_ready, req0_rw, rsp0_valid;
  logic [6:0] req0_addr;
  logic [7:0] req0_wdata, rsp0_rdata;
  logic [1:0] rsp0_err;
  logic req1_valid, req1_ready, req1_rw, rsp1_valid;
  logic [6:0] req1_addr;
  logic [7:0] req1_wdata, rsp1_rdata;
  logic [1:0] rsp1_err;
  logic m_start, m_rw, m_abort, m_busy, m_done, m_nack;
  logic [6:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic [1:0] grant;
  int checks = 0, errors = 0;
  int last = 1;
  logic pend [2];
  logic p_rw [2];
  logic [6:0] p_addr [2];
  logic [7:0] p_wdata [2];
  logic [7:0] exp_rdata [2];
  logic [1:0] exp_err [2];
  i2c_req_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_abort(m_abort),
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata), .grant(grant)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_reqs;
    req0_valid = pend[0]; req0_rw = p_rw[0]; req0_addr = p_addr[0]; req0_wdata = p_wdata[0];
    req1_valid = pend[1]; req1_rw = p_rw[1]; req1_addr = p_addr[1]; req1_wdata = p_wdata[1];
  endtask
  task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
    pend[i] = 1'b1; p_rw[i] = rw; p_addr[i] = a; p_wdata[i] = d;
  endtask
  task automatic chk_rsp_hold;
    chk("rsp0_rdata", rsp0_rdata, exp_rdata[0]);
    chk("rsp0_err", rsp0_err, exp_err[0]);
    chk("rsp1_rdata", rsp1_rdata, exp_rdata[1]);
    chk("rsp1_err", rsp1_err, exp_err[1]);
  endtask
  // mode 0: master completes dly cycles after m_start; mode 1: master never completes and
  // drops m_busy tail cycles after the abort
  task automatic txn(input int mode, input int dly, input logic nk, input logic [7:0] rd, input int tail);
    int w;
    drive_reqs;
    #1;
    w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
    chk("ready0", req0_ready, w == 0);
    chk("ready1", req1_ready, w == 1);
    tick;
    pend[w] = 1'b0;
    drive_reqs;
    #1;
    chk("m_start", m_start, 1);
    chk("grant", grant, (w == 0) ? 2'b01 : 2'b10);
    chk("m_rw", m_rw, p_rw[w]);
    chk("m_addr", m_addr, p_addr[w]);
    chk("m_wdata", m_wdata, p_wdata[w]);
    m_busy = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      tick;
      m_done = (mode == 0) && (k == dly);
      m_nack = nk;
      m_rdata = rd;
      #1;
      chk("m_abort", m_abort, (mode == 1) && (k == TO));
      chk("m_start_low", m_start, 0);
      chk("ready_busy", req0_ready | req1_ready, 0);
      if (m_done) break;
    end
    if (mode == 1)
      for (int j = 1; j <= tail; j++) begin
        tick;
        m_busy = j < tail;
        m_done = j == 1;
        #1;
        chk("abort_rsp", rsp0_valid | rsp1_valid, 0);
        chk("abort_once", m_abort, 0);
      end
    tick;
    m_done = 1'b0;
    m_busy = 1'b0;
    #1;
    exp_err[w] = (mode == 1) ? 2'b10 : {1'b0, nk};
    exp_rdata[w] = (mode == 0 && !nk && p_rw[w]) ? rd : 8'h00;
    last = w;
    chk("rsp0_valid", rsp0_valid, w == 0);
    chk("rsp1_valid", rsp1_valid, w == 1);
    chk_rsp_hold;
    tick;
    #1;
    chk("rsp_pulse", rsp0_valid | rsp1_valid, 0);
    chk("grant_idle", grant, 0);
    chk_rsp_hold;
  endtask
  initial begin
    reset = 1'b1;
    m_busy = 0; m_done = 0; m_nack = 0; m_rdata = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; p_rw[i] = 0; p_addr[i] = 0; p_wdata[i] = 0; exp_rdata[i] = 0; exp_err[i] = 0;
    end
    drive_reqs;
    repeat (2) tick;
    reset = 1'b0;
    #1;
    chk("rst_m_start", m_start, 0);
    chk("rst_m_abort", m_abort, 0);
    chk("rst_grant", grant, 0);
    chk("rst_m_cmd", {m_rw, m_addr, m_wdata}, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk_rsp_hold;
    chk("idle_ready0", req0_ready, 1);
    chk("idle_ready1", req1_ready, 0);
    tick;
    chk("idle_no_start", m_start, 0);
    set_req(0, 1'b0, 7'h50, 8'hA5);
    txn(0, 30, 1'b0, 8'h3C, 0);
    set_req(0, 1'b1, 7'h11, 8'h00);
    set_req(1, 1'b0, 7'h22, 8'h33);
    txn(0, 5, 1'b0, 8'h77, 0);
    txn(0, 7, 1'b0, 8'h88, 0);
    set_req(1, 1'b1, 7'h3C, 8'h00);
    txn(0, 12, 1'b1, 8'hFF, 0);
    set_req(0, 1'b0, 7'h44, 8'h12);
    txn(1, 0, 1'b0, 8'h00, 5);
    set_req(1, 1'b1, 7'h2A, 8'h00);
    txn(0, TO, 1'b0, 8'h5A, 0);
    set_req(0, 1'b1, 7'h01, 8'h00);
    drive_reqs;
    tick;
    pend[0] = 1'b0;
    drive_reqs;
    m_busy = 1'b1;
    repeat (20) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m_busy = 1'b0;
    set_req(1, 1'b0, 7'h6E, 8'hC3);
    drive_reqs;
    exp_rdata[0] = 0; exp_rdata[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
    last = 1;
    #1;
    chk("mid_m_abort", m_abort, 0);
    chk("mid_m_start", m_start, 0);
    chk("mid_grant", grant, 0);
    chk("mid_m_cmd", {m_rw, m_addr, m_wdata}, 0);
    chk("mid_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk_rsp_hold;
    txn(0, 9, 1'b0, 8'h00, 0);
    for (int n = 0; n < 40; n++) begin
      int mode, dly;
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
      if (!pend[0] && !pend[1]) set_req(n % 2, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
      mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      dly = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? TO : 1) : $urandom_range(1, TO);
      txn(mode, dly, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 6));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
